fir_mac_seq: RTL and testbench
==============================

// Module: fir_mac_seq
// PURPOSE
//  Time-multiplexed FIR multiply-accumulate engine with an internal delay line and coefficient file.
//  Computes y = sum(tap[k]*coef[k]) using one multiplier over NUM_TAPS cycles per sample.
//  Replaces the single-cycle combinational MAC.
//  Sits between the sensor sample stream and the output sink, with valid/ready on both sides.
// PARAMETERS
//  DATA_W     16                                 sample width, signed two's complement
//  COEF_W     16                                 coefficient width, signed two's complement
//  NUM_TAPS   8                                  filter length, >=2
//  ACC_W      DATA_W+COEF_W+$clog2(NUM_TAPS)     accumulator width; full precision, never overflows
//  OUT_W      16                                 output width
//  OUT_SHIFT  15                                 arithmetic right shift applied to acc before output
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  sample offered
//  in_ready   out  1                  engine can accept a sample
//  in_data    in   DATA_W             signed sample
//  coef_we    in   1                  coefficient write strobe
//  coef_addr  in   $clog2(NUM_TAPS)   coefficient index
//  coef_data  in   COEF_W             signed coefficient
//  out_valid  out  1                  result available
//  out_ready  in   1                  sink accepts result
//  out_data   out  OUT_W              signed filtered result
//  busy       out  1                  high in ACC or OUT state
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - state=IDLE; acc, tap[], coef[], out_data=0; out_valid=0; busy=0; in_ready=1 on the following cycle.
//   - Reset mid-ACC/OUT aborts the computation; no result is emitted.
//  FSM states: IDLE -> ACC -> OUT -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: tap[k]<=tap[k-1] for k>0, tap[0]<=in_data (tap0 newest); acc<=0; k<=0; go ACC.
//  ACC:
//   - One product per cycle: acc<=acc+sext(tap[k])*sext(coef[k]); k<=k+1.
//   - After the k=NUM_TAPS-1 product, latch scaled result into out_data and go OUT.
//  OUT:
//   - out_valid=1; out_data stable until out_valid&out_ready.
//   - On handshake go IDLE.
//   - in_ready=0 throughout ACC and OUT.
//  Latency: sample accepted at edge N -> out_valid high after edge N+NUM_TAPS+1.
//  Throughput: one sample per NUM_TAPS+2 cycles with out_ready held high.
//  Scaling: s = acc >>> OUT_SHIFT (floor toward -inf, no rounding); out_data = f(s), see CONFIGURATION.
//  Coefficient writes:
//   - Applied in IDLE only; coef[coef_addr]<=coef_data at that edge.
//   - Writes in ACC/OUT are dropped silently.
//   - coef_addr>=NUM_TAPS is ignored.
//  Simultaneous in_valid and coef_we in IDLE: both take effect; the new coefficient is used by this sample's computation.
//  in_valid while in_ready=0: not accepted; the source must hold the sample. No internal buffering.
// CONFIGURATION
//  FIR_SAT_EN defined:
//   - out_data = s clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - Extra output sat_flag (1 bit) added after out_data; =1 with out_valid when clamping occurred, else 0; reset 0.
//  FIR_SAT_EN undefined:
//   - out_data = s[OUT_W-1:0] (two's-complement wrap).
//   - No sat_flag port.
// TESTING (NUM_TAPS=8, DATA_W=COEF_W=OUT_W=16)
//  1. Impulse response. OUT_SHIFT=0, coef[k]=k+1; feed 1 then seven 0s -> out_data 1,2,3,4,5,6,7,8; ninth sample 0 -> 0.
//  2. Latency. in_valid accepted at edge 0 with out_ready=1 -> out_valid first high after edge 9; in_ready high again after edge 10.
//  3. Overflow. OUT_SHIFT=15; all coef=32767, all taps 32767 -> acc>>>15=262128; FIR_SAT_EN: 32767, sat_flag=1; else 0xFFF0 (-16).
//  4. Backpressure. Hold out_ready=0 for 5 cycles in OUT -> out_data/out_valid stable, in_ready=0; a held sample is accepted only after handshake.
//  5. Coefficient write rules. coef_we in ACC (addr 0, data 100) -> dropped; next result unchanged. Same write in IDLE coincident with a sample -> used.
//  6. Reset mid-operation. rst for 1 cycle at ACC k=4 -> no out_valid; taps/coefs read 0; next impulse with fresh coefs behaves as test 1.

Source files
------------

// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: valid/ready bundle for the sequential FIR MAC engine.
//
// Groups the three streams the engine talks to:
//   - sample input : in_valid, in_ready, in_data
//   - coef write   : coef_we, coef_addr, coef_data
//   - result output: out_valid, out_ready, out_data, plus busy status
// Modports:
//   master - the surrounding system (sample source, coefficient writer, result sink)
//   slave  - the engine itself
// When FIR_SAT_EN is defined the bundle also carries sat_flag (engine -> sink).
// The parameters must match those given to fir_mac_seq.
interface fir_mac_seq_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned NUM_TAPS = 8,
  parameter int unsigned OUT_W    = 16
);
  localparam int unsigned AddrW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [AddrW-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
`ifdef FIR_SAT_EN
  logic                     sat_flag;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data, busy, sat_flag
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data, busy, sat_flag
  );
`else
  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR multiply-accumulate engine.
//
// Holds a NUM_TAPS delay line (tap 0 newest) and a coefficient file, and computes
// y = sum(tap[k] * coef[k]) with a single multiplier, one product per cycle.
// Flow: IDLE (accept sample, shift delay line) -> ACC (NUM_TAPS products, then one
// cycle to scale and register the result) -> OUT (hold result until the sink takes it).
//
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - synchronous reset, active-high
//   bus  - fir_mac_seq_if.slave: sample in (valid/ready), coefficient write port,
//          result out (valid/ready) and busy status
//
// Scaling: s = acc >>> OUT_SHIFT (floor). Output is s wrapped to OUT_W bits, or,
// with macro FIR_SAT_EN defined, s clamped to the OUT_W signed range with
// bus.sat_flag raised alongside out_valid when clamping happened.
// Coefficient writes are honoured only in IDLE; out-of-range addresses are ignored.
// Assumes ACC_W >= OUT_W.
module fir_mac_seq #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NUM_TAPS  = 8,
  parameter int unsigned ACC_W     = DATA_W + COEF_W + $clog2(NUM_TAPS),
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_SHIFT = 15
) (
  input logic          clk,
  input logic          rst,
  fir_mac_seq_if.slave bus
);

  localparam int unsigned AddrW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned CntW  = $clog2(NUM_TAPS + 1);
  localparam int unsigned ProdW = DATA_W + COEF_W;

  // k counts 0..NUM_TAPS; the extra value is the scale/latch cycle.
  localparam logic [CntW-1:0] LastCnt  = CntW'(NUM_TAPS);
  localparam logic [AddrW:0]  NumTapsA = (AddrW + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] taps_q [NUM_TAPS];
  logic signed [DATA_W-1:0] taps_d [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_d [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]          k_q, k_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  // Single shared multiplier datapath.
  logic [AddrW-1:0]         k_idx;
  logic signed [DATA_W-1:0] tap_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [ProdW-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // Scaled result of the finished accumulation.
  logic signed [OUT_W-1:0]  out_c;
  logic                     sat_c;

  // Clamp index on the latch cycle so the mux never reads past the arrays.
  assign k_idx    = (k_q < LastCnt) ? k_q[AddrW-1:0] : '0;
  assign tap_sel  = taps_q[k_idx];
  assign coef_sel = coef_q[k_idx];
  assign prod     = ProdW'(tap_sel) * ProdW'(coef_sel);
  assign prod_ext = ACC_W'(prod);

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] OutMax = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OutMin = ACC_W'(-(longint'(1) <<< (OUT_W - 1)));

  logic signed [ACC_W-1:0] acc_shr;

  always_comb begin
    acc_shr = acc_q >>> OUT_SHIFT;
    out_c   = acc_shr[OUT_W-1:0];
    sat_c   = 1'b0;
    if (acc_shr > OutMax) begin
      out_c = OutMax[OUT_W-1:0];
      sat_c = 1'b1;
    end else if (acc_shr < OutMin) begin
      out_c = OutMin[OUT_W-1:0];
      sat_c = 1'b1;
    end
  end
`else
  always_comb begin
    // Two's-complement wrap: keep only the low OUT_W bits of the shifted sum.
    out_c = OUT_W'(acc_q >>> OUT_SHIFT);
    sat_c = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    taps_d      = taps_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;

    case (state_q)
      StIdle: begin
        // A write coincident with an accepted sample lands before its first product.
        if (bus.coef_we && ({1'b0, bus.coef_addr} < NumTapsA)) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end
        if (bus.in_valid) begin
          taps_d[0] = bus.in_data;
          for (int unsigned i = 1; i < NUM_TAPS; i++) begin
            taps_d[i] = taps_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = StAcc;
        end
      end

      StAcc: begin
        if (k_q == LastCnt) begin
          out_data_d  = out_c;
          out_valid_d = 1'b1;
          sat_d       = sat_c;
          state_d     = StOut;
        end else begin
          acc_d = acc_q + prod_ext;
          k_d   = k_q + CntW'(1);
        end
      end

      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          sat_d       = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      taps_q      <= '{default: '0};
      coef_q      <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      taps_q      <= taps_d;
      coef_q      <= coef_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef FIR_SAT_EN
  assign bus.sat_flag  = sat_q;
`else
  // sat_q only matters in the saturating build.
  logic unused_sat;
  assign unused_sat = sat_q ^ sat_c;
`endif

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: two engines (OUT_SHIFT 0 and 15) share one stimulus stream.
// A transaction-level model tracks taps/coefs and the spec timing and is compared
// to both engines on every falling edge; directed phases pin the model with literals.
module tb_fir_mac_seq;
  localparam int NT = 8;

  logic clk;
  logic rst;
  logic                tb_in_valid;
  logic signed [15:0]  tb_in_data;
  logic                tb_coef_we;
  logic [2:0]          tb_coef_addr;
  logic signed [15:0]  tb_coef_data;
  logic                tb_out_ready;

  int total;
  int bad;

  fir_mac_seq_if bus0 ();
  fir_mac_seq_if bus1 ();

  assign bus0.in_valid  = tb_in_valid;
  assign bus0.in_data   = tb_in_data;
  assign bus0.coef_we   = tb_coef_we;
  assign bus0.coef_addr = tb_coef_addr;
  assign bus0.coef_data = tb_coef_data;
  assign bus0.out_ready = tb_out_ready;
  assign bus1.in_valid  = tb_in_valid;
  assign bus1.in_data   = tb_in_data;
  assign bus1.coef_we   = tb_coef_we;
  assign bus1.coef_addr = tb_coef_addr;
  assign bus1.coef_data = tb_coef_data;
  assign bus1.out_ready = tb_out_ready;

  fir_mac_seq #(.OUT_SHIFT(0))  u0 (.clk(clk), .rst(rst), .bus(bus0));
  fir_mac_seq #(.OUT_SHIFT(15)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_phase;  // 0 idle, 1 computing, 2 result offered
  int     m_cnt;
  bit     m_init;
  longint m_taps [NT];
  longint m_coef [NT];
  longint m_exp  [2];
  bit     m_sat  [2];

  function automatic longint scale(input longint acc, input int sh, output bit sat);
    longint s;
    s   = acc >>> sh;
    sat = 1'b0;
`ifdef FIR_SAT_EN
    if (s > 32767) begin
      sat = 1'b1;
      return 32767;
    end
    if (s < -32768) begin
      sat = 1'b1;
      return -32768;
    end
    return s;
`else
    return longint'(shortint'(s));
`endif
  endfunction

  task automatic model_step();
    longint acc;
    if (rst) begin
      m_init  = 1'b1;
      m_phase = 0;
      m_cnt   = 0;
      for (int i = 0; i < NT; i++) begin
        m_taps[i] = 0;
        m_coef[i] = 0;
      end
      m_exp[0] = 0;
      m_exp[1] = 0;
      m_sat[0] = 0;
      m_sat[1] = 0;
    end else if (m_init) begin
      case (m_phase)
        0: begin
          if (tb_coef_we) m_coef[int'(tb_coef_addr)] = longint'(tb_coef_data);
          if (tb_in_valid) begin
            for (int i = NT - 1; i > 0; i--) m_taps[i] = m_taps[i-1];
            m_taps[0] = longint'(tb_in_data);
            m_phase   = 1;
            m_cnt     = 0;
          end
        end
        1: begin
          m_cnt++;
          // Result appears NT+1 edges after acceptance.
          if (m_cnt == NT + 1) begin
            acc = 0;
            for (int i = 0; i < NT; i++) acc += m_taps[i] * m_coef[i];
            m_exp[0] = scale(acc, 0, m_sat[0]);
            m_exp[1] = scale(acc, 15, m_sat[1]);
            m_phase  = 2;
          end
        end
        default: if (tb_out_ready) m_phase = 0;
      endcase
    end
  endtask

  initial begin
    m_init = 1'b0;
    m_phase = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("u0_in_ready", bus0.in_ready, m_phase == 0);
        chk("u0_busy", bus0.busy, m_phase != 0);
        chk("u0_out_valid", bus0.out_valid, m_phase == 2);
        chk("u1_out_valid", bus1.out_valid, m_phase == 2);
        if (m_phase == 2) begin
          chk("u0_out_data", bus0.out_data, m_exp[0]);
          chk("u1_out_data", bus1.out_data, m_exp[1]);
        end
`ifdef FIR_SAT_EN
        chk("u0_sat_flag", bus0.sat_flag, (m_phase == 2) ? m_sat[0] : 0);
        chk("u1_sat_flag", bus1.sat_flag, (m_phase == 2) ? m_sat[1] : 0);
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input int data);
    tb_coef_we   = 1'b1;
    tb_coef_addr = 3'(addr);
    tb_coef_data = 16'(data);
    step();
    tb_coef_we = 1'b0;
  endtask

  task automatic send(input int data);
    int guard;
    guard = 0;
    tb_in_valid = 1'b1;
    tb_in_data  = 16'(data);
    while (!bus0.in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 1, 0);
    step();
    tb_in_valid = 1'b0;
  endtask

  task automatic get(output longint r0, output longint r1, output bit s1);
    int guard;
    guard = 0;
    tb_out_ready = 1'b1;
    while (!bus0.out_valid && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("get_timeout", 1, 0);
    r0 = longint'(bus0.out_data);
    r1 = longint'(bus1.out_data);
`ifdef FIR_SAT_EN
    s1 = bus1.sat_flag;
`else
    s1 = 1'b0;
`endif
    step();
  endtask

  task automatic impulse_check(input string tag);
    longint r0, r1;
    bit s1;
    for (int k = 0; k < NT; k++) wr_coef(k, k + 1);
    for (int i = 0; i <= NT; i++) begin
      send((i == 0) ? 1 : 0);
      get(r0, r1, s1);
      chk(tag, r0, (i < NT) ? i + 1 : 0);
    end
  endtask

  initial begin
    longint r0, r1;
    bit s1;
    bit took;
    int guard;
    total = 0;
    bad = 0;
    rst = 1'b0;
    tb_in_valid = 1'b0;
    tb_in_data = '0;
    tb_coef_we = 1'b0;
    tb_coef_addr = '0;
    tb_coef_data = '0;
    tb_out_ready = 1'b1;
    step();
    do_reset(2);

    // Reset state.
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_out_data", bus0.out_data, 0);

    // Impulse response with OUT_SHIFT=0.
    impulse_check("impulse");

    // Latency: accept at edge 0, out_valid after edge 9, in_ready back after edge 10.
    tb_in_valid = 1'b1;
    tb_in_data = 16'sd0;
    step();
    tb_in_valid = 1'b0;
    chk("lat_busy0", bus0.busy, 1);
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("lat_out_valid", bus0.out_valid, e == 9);
      chk("lat_in_ready", bus0.in_ready, e >= 10);
    end

    // Overflow: all taps and coefs at 32767.
    for (int k = 0; k < NT; k++) wr_coef(k, 32767);
    for (int i = 0; i < NT; i++) begin
      send(32767);
      get(r0, r1, s1);
    end
`ifdef FIR_SAT_EN
    chk("ovf_data", r1, 32767);
    chk("ovf_sat", s1, 1);
`else
    chk("ovf_data", r1, -16);
`endif

    // Backpressure: result held, new sample waits for the handshake.
    tb_out_ready = 1'b0;
    send(100);
    guard = 0;
    while (!bus0.out_valid && guard < 100) begin
      step();
      guard++;
    end
    tb_in_valid = 1'b1;
    tb_in_data = -16'sd5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", bus0.out_valid, 1);
      chk("bp_in_ready", bus0.in_ready, 0);
    end
    tb_out_ready = 1'b1;
    step();
    chk("bp_idle_after_hs", bus0.in_ready, 1);
    step();
    chk("bp_accepted", bus0.busy, 1);
    tb_in_valid = 1'b0;
    get(r0, r1, s1);

    // Coefficient write rules.
    do_reset(1);
    for (int k = 0; k < NT; k++) wr_coef(k, k + 1);
    send(2);
    step();
    tb_coef_we = 1'b1;
    tb_coef_addr = 3'd0;
    tb_coef_data = 16'sd100;
    step();
    tb_coef_we = 1'b0;
    get(r0, r1, s1);
    chk("coef_drop", r0, 2);
    tb_coef_we = 1'b1;
    tb_coef_addr = 3'd0;
    tb_coef_data = 16'sd100;
    send(3);
    tb_coef_we = 1'b0;
    get(r0, r1, s1);
    chk("coef_coincident", r0, 304);

    // Reset in the middle of accumulation (k=4).
    send(1);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_valid", bus0.out_valid, 0);
    end
    impulse_check("impulse_after_rst");
    do_reset(1);
    send(5);
    get(r0, r1, s1);
    chk("coef_zero_after_rst", r0, 0);

    // Randomised traffic; the per-cycle compare does the checking.
    took = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!tb_in_valid || took) begin
        tb_in_valid = ($urandom_range(0, 1) == 1);
        tb_in_data = 16'($urandom);
      end
      took = tb_in_valid && bus0.in_ready;
      tb_coef_we = ($urandom_range(0, 3) == 0);
      tb_coef_addr = 3'($urandom);
      tb_coef_data = 16'($urandom);
      tb_out_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    tb_in_valid = 1'b0;
    tb_coef_we = 1'b0;
    tb_out_ready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
